scr_seq_ctrl: RTL

- Sequencing controller for the 33-bit side-stream scrambler (x^33 + x^13 + 1 LFSR) in the 100BASE-T1 PCS transmit path.
- Clears and seeds the scrambler, then advances it one step per PCS symbol strobe through a fixed-length training phase and into the data phase.
- Preserves scrambler state between strobes by feeding the LFSR value back as its seed.
- Detects the all-zero LFSR lockup state and flags it.

---
 rtl/scr_seq_ctrl.sv | 133 +++++++++++++
 1 files changed

// File: rtl/scr_seq_ctrl.sv
// Clear/seed/train/data sequencer for the 33-bit side-stream scrambler (x^33 + x^13 + 1).
// Optional macro SCR_LOCKUP_RECOVER_EN: on all-zero lockup re-run clear/seed/train instead of idling.
module scr_seq_ctrl #(
  parameter logic [32:0] SEED_DEFAULT = 33'h0_0000_0001,
  parameter int unsigned TRAIN_SYMS   = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [32:0] cfg_seed,
  input  logic        cfg_seed_wr,
  input  logic        start,
  input  logic        stop,
  input  logic        sym_strobe,
  input  logic [32:0] scr_rand,
  output logic        scr_load,
  output logic        scr_valid,
  output logic [32:0] scr_seed,
  output logic [1:0]  phase,
  output logic        train_done,
  output logic        busy,
  output logic        lockup_err
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CLEAR,
    ST_SEED,
    ST_TRAIN,
    ST_DATA
  } state_t;

  localparam logic [15:0] TRAIN_LAST = 16'(TRAIN_SYMS);

  state_t      state;
  state_t      state_nxt;
  logic [32:0] seed_reg;
  logic [15:0] sym_cnt;
  logic        strobe_q;
  logic        active;
  logic        lockup;
  logic        train_last;

  assign active     = (state == ST_TRAIN) || (state == ST_DATA);
  // A gap cycle with a zero register means the LFSR is stuck and can never recover by shifting.
  assign lockup     = active && !strobe_q && (scr_rand == '0);
  assign train_last = strobe_q && (sym_cnt >= (TRAIN_LAST - 16'd1));

  always_comb begin
    state_nxt = state;
    if (stop) begin
      state_nxt = ST_IDLE;
    end else if (lockup) begin
`ifdef SCR_LOCKUP_RECOVER_EN
      state_nxt = ST_CLEAR;
`else
      state_nxt = ST_IDLE;
`endif
    end else begin
      case (state)
        ST_IDLE:  if (start) state_nxt = ST_CLEAR;
        ST_CLEAR: state_nxt = ST_SEED;
        ST_SEED:  state_nxt = ST_TRAIN;
        ST_TRAIN: if (train_last) state_nxt = ST_DATA;
        default:  state_nxt = state;
      endcase
    end
  end

  always_comb begin
    scr_load   = 1'b0;
    scr_valid  = 1'b0;
    scr_seed   = seed_reg;
    phase      = 2'd0;
    train_done = 1'b0;
    busy       = (state != ST_IDLE);
    case (state)
      ST_IDLE: begin
        scr_load = 1'b1;
      end
      ST_CLEAR: begin
        scr_load = 1'b1;
        phase    = 2'd1;
      end
      ST_SEED: begin
        phase = 2'd1;
      end
      ST_TRAIN: begin
        scr_valid = strobe_q;
        scr_seed  = scr_rand;
        phase     = 2'd2;
      end
      ST_DATA: begin
        scr_valid  = strobe_q;
        scr_seed   = scr_rand;
        phase      = 2'd3;
        train_done = 1'b1;
      end
      default: begin
        scr_load = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_IDLE;
      seed_reg   <= SEED_DEFAULT;
      sym_cnt    <= '0;
      strobe_q   <= 1'b0;
      lockup_err <= 1'b0;
    end else begin
      state <= state_nxt;
      if (cfg_seed_wr) begin
        seed_reg <= (cfg_seed == '0) ? SEED_DEFAULT : cfg_seed;
      end
      // Strobes outside TRAIN/DATA are discarded rather than queued.
      strobe_q <= active && sym_strobe;
      if (state == ST_CLEAR) begin
        sym_cnt <= '0;
      end else if ((state == ST_TRAIN) && strobe_q && (sym_cnt != 16'hFFFF)) begin
        sym_cnt <= sym_cnt + 16'd1;
      end
      if (!stop) begin
        if (lockup) begin
          lockup_err <= 1'b1;
        end else if ((state == ST_IDLE) && start) begin
          lockup_err <= 1'b0;
        end
      end
    end
  end

endmodule
